// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, word-read issue and prefetch FIFO feeding the cpu core
// Optional feature macro: FETCH_STATS_EN (adds fetch_count / flush_count)
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   imem_addr/rd/rdata   synchronous instruction memory, data one cycle after rd
//   instr/instr_pc       FIFO head word and its byte address
//   instr_valid          FIFO non-empty; transfer when cpu_waiting is also high
//   redirect/redirect_pc flush the FIFO and restart fetch at redirect_pc & ~3
//   halt                 level, blocks new reads while high
//   fetch_count          (FETCH_STATS_EN) instructions handed to the cpu
//   flush_count          (FETCH_STATS_EN) redirects seen
module instr_fetch_unit #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_rd,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        cpu_waiting,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [15:0] flush_count
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic {RUN, DROP} state_t;

    state_t        state, state_nx;
    logic [31:0]   pc, inflight_pc, hold_instr, hold_pc;
    logic          inflight, push, pop;
    logic [31:0]   mem_w  [FIFO_DEPTH];
    logic [31:0]   mem_pc [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;

    assign imem_addr   = pc;
    assign instr_valid = count != '0;
    // Registered copy of the shown head keeps instr/instr_pc stable once empty
    assign instr       = instr_valid ? mem_w[rptr]  : hold_instr;
    assign instr_pc    = instr_valid ? mem_pc[rptr] : hold_pc;

    always_comb begin
        state_nx = state;
        if (redirect)
            state_nx = inflight ? DROP : RUN;
        else if (state == DROP)
            state_nx = RUN;
        // Credits count the word still in flight; a same-cycle pop frees none
        imem_rd = !rst && !halt && !redirect && (count + CW'(inflight)) < FULL;
        // Words landing in a redirect cycle or in DROP belong to the old stream
        push    = inflight && state == RUN && !redirect;
        pop     = instr_valid && cpu_waiting;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            hold_instr  <= '0;
            hold_pc     <= '0;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
        end else begin
            state      <= state_nx;
            inflight   <= imem_rd;
            hold_instr <= instr;
            hold_pc    <= instr_pc;
            if (imem_rd) begin
                pc          <= pc + 32'd4;
                inflight_pc <= pc;
            end
            if (redirect) begin
                pc    <= redirect_pc & ~32'd3;
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push)
                    wptr <= wptr + 1'b1;
                if (pop)
                    rptr <= rptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_w[wptr]  <= imem_rdata;
            mem_pc[wptr] <= inflight_pc;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            fetch_count <= fetch_count + 32'(pop);
            flush_count <= flush_count + 16'(redirect);
        end
    end
`endif

    assert property (@(posedge clk) disable iff (rst) !(push && count == FULL));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized fetch traffic checked against a queue-based model
module tb_instr_fetch_unit;
    localparam int DEPTH = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, imem_rd, instr_valid, cpu_waiting, redirect, halt;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
`endif

    int total = 0;
    int bad = 0;

    instr_fetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .cpu_waiting(cpu_waiting), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt)
`ifdef FETCH_STATS_EN
        , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a | 32'hE3A0_0000;
    endfunction

    always @(posedge clk) imem_rdata <= imem_rd ? word_at(imem_addr) : $urandom();

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: FIFO as a queue of {pc, word}, one outstanding read, a drop flag
    logic [63:0] m_q[$];
    logic [31:0] m_pc, m_pend_addr, m_hi, m_hp, m_fc, m_flc;
    logic        m_pend, m_drop;

    initial forever begin
        logic        exp_rd, exp_v, pop;
        logic [31:0] exp_i, exp_p;
        @(negedge clk);
        if (rst) begin
            m_q.delete();
            m_pc = RPC; m_pend = 0; m_drop = 0; m_hi = 0; m_hp = 0; m_fc = 0; m_flc = 0;
            chk("rst_rd", imem_rd, 0);
            chk("rst_valid", instr_valid, 0);
            chk("rst_instr", instr, 0);
            chk("rst_pc", instr_pc, 0);
            chk("rst_addr", imem_addr, RPC);
        end else begin
            exp_rd = !halt && !redirect && (m_q.size() + int'(m_pend)) < DEPTH;
            exp_v  = m_q.size() != 0;
            exp_i  = exp_v ? m_q[0][31:0]  : m_hi;
            exp_p  = exp_v ? m_q[0][63:32] : m_hp;
            chk("rd", imem_rd, exp_rd);
            chk("addr", imem_addr, m_pc);
            chk("valid", instr_valid, exp_v);
            chk("instr", instr, exp_i);
            chk("instr_pc", instr_pc, exp_p);
`ifdef FETCH_STATS_EN
            chk("fetch_count", fetch_count, m_fc);
            chk("flush_count", {16'b0, flush_count}, {16'b0, m_flc[15:0]});
`endif
            pop  = exp_v && cpu_waiting;
            m_hi = exp_i;
            m_hp = exp_p;
            if (pop) m_fc++;
            if (redirect) begin
                m_q.delete();
                m_pc   = redirect_pc & ~32'd3;
                m_drop = m_pend;
                m_flc++;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (m_pend && !m_drop) m_q.push_back({m_pend_addr, word_at(m_pend_addr)});
                m_drop = 0;
            end
            if (exp_rd) begin
                m_pend_addr = m_pc;
                m_pc += 4;
            end
            m_pend = exp_rd;
        end
    end

    task automatic do_reset(input logic wait_in);
        @(posedge clk); #1 rst = 1; cpu_waiting = wait_in; halt = 0; redirect = 0;
        @(posedge clk); #1 rst = 0;
    endtask

    initial begin
        int n, k;
        logic [31:0] got [5];
        rst = 1; cpu_waiting = 0; redirect = 0; redirect_pc = 0; halt = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0; cpu_waiting = 1;
        @(negedge clk); chk("t1_addr0", imem_addr, 0); chk("t1_rd0", imem_rd, 1);
        @(negedge clk); chk("t1_addr1", imem_addr, 4); chk("t1_v1", instr_valid, 0);
        @(negedge clk); chk("t1_v2", instr_valid, 1); chk("t1_i2", instr, 32'hE3A0_0000);
        chk("t1_p2", instr_pc, 0);
        @(negedge clk); chk("t1_i3", instr, 32'hE3A0_0004); chk("t1_p3", instr_pc, 4);

        do_reset(0);
        n = 0;
        repeat (10) begin @(negedge clk); n += int'(imem_rd); end
        chk("t2_reads", n, 4);
        @(posedge clk); #1 cpu_waiting = 1;
        k = 0;
        for (int c = 0; c < 20 && k < 5; c++) begin
            @(negedge clk);
            if (instr_valid) begin got[k] = instr_pc; k++; end
        end
        chk("t2_pops", k, 5);
        for (int i = 0; i < k; i++) chk("t2_order", got[i], 32'(4 * i));

        for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (m_pend) break; end
        chk("t3_pend", m_pend, 1);
        redirect = 1; redirect_pc = 32'h0000_0103;
        @(posedge clk); #1 redirect = 0;
        @(negedge clk); chk("t3_addr", imem_addr, 32'h100);
        k = 0;
        for (int c = 0; c < 10 && k == 0; c++) begin
            if (c > 0) @(negedge clk);
            if (instr_valid) begin
                k = 1;
                chk("t3_pc", instr_pc, 32'h100);
                chk("t3_instr", instr, 32'hE3A0_0100);
            end
        end
        chk("t3_got", k, 1);
`ifdef FETCH_STATS_EN
        chk("t3_flush", {16'b0, flush_count}, 1);
`endif

        @(posedge clk); #1 cpu_waiting = 0;
        repeat (2) @(posedge clk);
        #1 halt = 1; cpu_waiting = 1;
        n = 0;
        repeat (5) begin @(negedge clk); n += int'(imem_rd); end
        chk("t4_reads", n, 0);
        chk("t4_empty", instr_valid, 0);
        @(posedge clk); #1 halt = 0;
        @(negedge clk); chk("t4_resume", imem_rd, 1);

        @(posedge clk); #1 redirect = 1; redirect_pc = 32'hFFFF_FFFF;
        @(posedge clk); #1 redirect = 0;
        @(negedge clk); chk("t5_addr", imem_addr, 32'hFFFF_FFFC); chk("t5_rd", imem_rd, 1);
        @(negedge clk); chk("t5_wrap", imem_addr, 0);

        repeat (2000) begin
            @(posedge clk); #1;
            cpu_waiting = $urandom_range(0, 9) < 7;
            halt        = $urandom_range(0, 9) == 0;
            redirect    = $urandom_range(0, 19) == 0;
            redirect_pc = $urandom();
        end

        do_reset(0);
        for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (m_q.size() == 3) break; end
        chk("t7_fill", m_q.size(), 3);
        chk("t7_valid_before", instr_valid, 1);
        rst = 1;
        #1 chk("t7_valid", instr_valid, 0); chk("t7_instr", instr, 0); chk("t7_pc", instr_pc, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk); chk("t7_addr", imem_addr, RPC); chk("t7_rd", imem_rd, 1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
